// File: rtl/buyruk_onbellegi_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, bus widths
// and the helper that sizes the tag field from the geometry parameters.
package buyruk_onbellegi_pkg;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        ISTEK  = 2'd1,
        DOLDUR = 2'd2
    } durum_t;

    localparam int ADRES_W    = 32;
    localparam int KELIME_W   = 32;
    localparam int BAYT_OFS_W = 2;

    function automatic int etiket_genisligi(input int satir_sayisi, input int kelime_sayisi);
        return ADRES_W - BAYT_OFS_W - $clog2(satir_sayisi) - $clog2(kelime_sayisi);
    endfunction

endpackage

// File: rtl/onbellek_satir_dizisi.sv
// Flop-based tag/data/valid storage: one combinational read port for the
// core lookup and one write port driven by the line fill.
module onbellek_satir_dizisi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI  = 16,
    parameter int KELIME_SAYISI = 4,
    parameter int ETIKET_W      = 24,
    localparam int SATIR_W      = $clog2(SATIR_SAYISI),
    localparam int KELIME_ADR_W = $clog2(KELIME_SAYISI)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [SATIR_W-1:0]      oku_satir_i,
    input  logic [KELIME_ADR_W-1:0] oku_kelime_i,
    output logic                    oku_gecerli_o,
    output logic [ETIKET_W-1:0]     oku_etiket_o,
    output logic [KELIME_W-1:0]     oku_veri_o,
    input  logic                    yaz_en_i,
    input  logic [SATIR_W-1:0]      yaz_satir_i,
    input  logic [KELIME_ADR_W-1:0] yaz_kelime_i,
    input  logic [KELIME_W-1:0]     yaz_veri_i,
    input  logic                    yaz_etiket_en_i,
    input  logic [ETIKET_W-1:0]     yaz_etiket_i,
    input  logic                    yaz_gecerli_i,
    input  logic                    tumunu_sil_i
);

    logic [KELIME_W-1:0] veri_r   [SATIR_SAYISI][KELIME_SAYISI];
    logic [ETIKET_W-1:0] etiket_r [SATIR_SAYISI];
    logic [SATIR_SAYISI-1:0] gecerli_r;

    // Valid bits: global clear first, then the completing line's own bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gecerli_r <= '0;
        end else begin
            if (tumunu_sil_i) begin
                gecerli_r <= '0;
            end
            if (yaz_etiket_en_i) begin
                gecerli_r[yaz_satir_i] <= yaz_gecerli_i;
            end
        end
    end

    // Data words, one per fill beat
    always_ff @(posedge clk_i) begin
        if (yaz_en_i) begin
            veri_r[yaz_satir_i][yaz_kelime_i] <= yaz_veri_i;
        end
    end

    // Tag written together with the final fill word
    always_ff @(posedge clk_i) begin
        if (yaz_etiket_en_i) begin
            etiket_r[yaz_satir_i] <= yaz_etiket_i;
        end
    end

    assign oku_gecerli_o = gecerli_r[oku_satir_i];
    assign oku_etiket_o  = etiket_r[oku_satir_i];
    assign oku_veri_o    = veri_r[oku_satir_i][oku_kelime_i];

endmodule

// File: rtl/buyruk_onbellegi.sv
// Direct-mapped instruction cache with zero-latency hits and a
// request/fill state machine towards lower memory.
module buyruk_onbellegi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI  = 16,
    parameter int KELIME_SAYISI = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cek_chip_select_n_i,
    input  logic [ADRES_W-1:0]  cek_adres_i,
    output logic                cek_bekle_o,
    output logic [KELIME_W-1:0] cek_deger_o,
    input  logic                onbellek_gecersiz_i,
    output logic                bel_istek_o,
    output logic [ADRES_W-1:0]  bel_adres_o,
    input  logic                bel_kabul_i,
    input  logic                bel_gecerli_i,
    input  logic [KELIME_W-1:0] bel_deger_i
);

    localparam int KELIME_ADR_W = $clog2(KELIME_SAYISI);
    localparam int SATIR_W      = $clog2(SATIR_SAYISI);
    localparam int ETIKET_W     = etiket_genisligi(SATIR_SAYISI, KELIME_SAYISI);
    localparam int SATIR_LSB    = BAYT_OFS_W + KELIME_ADR_W;
    localparam int ETIKET_LSB   = SATIR_LSB + SATIR_W;

    durum_t                  durum_r;
    durum_t                  durum_d_s;
    logic [KELIME_ADR_W-1:0] sayac_r;
    logic                    bel_istek_r;
    logic [ADRES_W-1:0]      bel_adres_r;
    logic                    bekleyen_gecersiz_r;

    logic [KELIME_ADR_W-1:0] cek_kelime_s;
    logic [SATIR_W-1:0]      cek_satir_s;
    logic [ETIKET_W-1:0]     cek_etiket_s;
    logic [SATIR_W-1:0]      dolum_satir_s;
    logic [ETIKET_W-1:0]     dolum_etiket_s;
    logic                    oku_gecerli_s;
    logic [ETIKET_W-1:0]     oku_etiket_s;
    logic [KELIME_W-1:0]     oku_veri_s;
    logic                    isabet_s;
    logic                    dolum_kelime_s;
    logic                    son_kelime_s;
    logic                    dolum_bitti_s;
    logic                    yaz_en_s;
    logic                    etiket_yaz_s;
    logic                    gecerli_yap_s;
    logic                    cek_bekle_s;
    logic [KELIME_W-1:0]     cek_deger_s;
    logic                    unused_adres_s;

    assign cek_kelime_s   = cek_adres_i[SATIR_LSB-1:BAYT_OFS_W];
    assign cek_satir_s    = cek_adres_i[ETIKET_LSB-1:SATIR_LSB];
    assign cek_etiket_s   = cek_adres_i[ADRES_W-1:ETIKET_LSB];
    assign unused_adres_s = ^cek_adres_i[BAYT_OFS_W-1:0];

    // The fill is steered only by the latched address, never by the core's
    assign dolum_satir_s  = bel_adres_r[ETIKET_LSB-1:SATIR_LSB];
    assign dolum_etiket_s = bel_adres_r[ADRES_W-1:ETIKET_LSB];

    assign isabet_s       = ~cek_chip_select_n_i & oku_gecerli_s & (oku_etiket_s == cek_etiket_s);
    assign dolum_kelime_s = (durum_r == DOLDUR) & bel_gecerli_i;
    assign son_kelime_s   = (sayac_r == KELIME_ADR_W'(KELIME_SAYISI - 1));
    assign dolum_bitti_s  = dolum_kelime_s & son_kelime_s;

    onbellek_satir_dizisi #(
        .SATIR_SAYISI  (SATIR_SAYISI),
        .KELIME_SAYISI (KELIME_SAYISI),
        .ETIKET_W      (ETIKET_W)
    ) u_satir_dizisi (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .oku_satir_i     (cek_satir_s),
        .oku_kelime_i    (cek_kelime_s),
        .oku_gecerli_o   (oku_gecerli_s),
        .oku_etiket_o    (oku_etiket_s),
        .oku_veri_o      (oku_veri_s),
        .yaz_en_i        (yaz_en_s),
        .yaz_satir_i     (dolum_satir_s),
        .yaz_kelime_i    (sayac_r),
        .yaz_veri_i      (bel_deger_i),
        .yaz_etiket_en_i (etiket_yaz_s),
        .yaz_etiket_i    (dolum_etiket_s),
        .yaz_gecerli_i   (gecerli_yap_s),
        .tumunu_sil_i    (onbellek_gecersiz_i)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_r <= BOSTA;
        end else begin
            durum_r <= durum_d_s;
        end
    end

    // Next-state logic
    always_comb begin
        durum_d_s = durum_r;
        case (durum_r)
            BOSTA: begin
                if (~cek_chip_select_n_i & ~isabet_s) begin
                    durum_d_s = ISTEK;
                end else begin
                    durum_d_s = BOSTA;
                end
            end
            ISTEK: begin
                if (bel_kabul_i) begin
                    durum_d_s = DOLDUR;
                end else begin
                    durum_d_s = ISTEK;
                end
            end
            DOLDUR: begin
                if (dolum_bitti_s) begin
                    durum_d_s = BOSTA;
                end else begin
                    durum_d_s = DOLDUR;
                end
            end
            default: durum_d_s = BOSTA;
        endcase
    end

    // Outputs and storage write controls
    always_comb begin
        yaz_en_s      = dolum_kelime_s;
        etiket_yaz_s  = dolum_bitti_s;
        // A fence.i seen at any point of the fill keeps the line invalid
        gecerli_yap_s = ~bekleyen_gecersiz_r & ~onbellek_gecersiz_i;
        cek_bekle_s   = ~cek_chip_select_n_i & (~isabet_s | (durum_r != BOSTA));
        if ((durum_r == BOSTA) && isabet_s) begin
            cek_deger_s = oku_veri_s;
        end else begin
            cek_deger_s = 32'h0000_0000;
        end
    end

    // Fill bookkeeping: request, latched line address, word counter, pending invalidate
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sayac_r             <= '0;
            bel_istek_r         <= 1'b0;
            bel_adres_r         <= 32'h0000_0000;
            bekleyen_gecersiz_r <= 1'b0;
        end else begin
            bel_istek_r <= (durum_d_s == ISTEK);
            if ((durum_r == BOSTA) && (durum_d_s == ISTEK)) begin
                bel_adres_r <= {cek_etiket_s, cek_satir_s, {SATIR_LSB{1'b0}}};
            end
            if (dolum_kelime_s) begin
                sayac_r <= sayac_r + KELIME_ADR_W'(1);
            end
            if ((durum_r == BOSTA) || dolum_bitti_s) begin
                bekleyen_gecersiz_r <= 1'b0;
            end else begin
                bekleyen_gecersiz_r <= bekleyen_gecersiz_r | onbellek_gecersiz_i;
            end
        end
    end

    assign bel_istek_o = bel_istek_r;
    assign bel_adres_o = bel_adres_r;
    assign cek_bekle_o = cek_bekle_s;
    assign cek_deger_o = cek_deger_s;

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Self-checking bench for buyruk_onbellegi: a behavioural lower-memory
// responder plus a scoreboard of expected fetch results.
module tb_buyruk_onbellegi;
    import buyruk_onbellegi_pkg::*;

    localparam int KS = 4;
    localparam int SS = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cek_chip_select_n_i;
    logic [31:0] cek_adres_i;
    logic        cek_bekle_o;
    logic [31:0] cek_deger_o;
    logic        onbellek_gecersiz_i;
    logic        bel_istek_o;
    logic [31:0] bel_adres_o;
    logic        bel_kabul_i;
    logic        bel_gecerli_i;
    logic [31:0] bel_deger_i;

    int gecen  = 0;
    int toplam = 0;
    logic [31:0] beklenen_q[$];

    int kabul_gecikme   = 0;
    int bosluk          = 0;
    int gecersiz_kelime = -1;
    int istek_sayisi    = 0;
    int gonderilen      = 0;
    int kararsiz        = 0;
    logic [31:0] son_istek_adres = 32'h0;
    logic [31:0] yanit_adres;

    buyruk_onbellegi #(.SATIR_SAYISI(SS), .KELIME_SAYISI(KS)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .cek_chip_select_n_i (cek_chip_select_n_i),
        .cek_adres_i         (cek_adres_i),
        .cek_bekle_o         (cek_bekle_o),
        .cek_deger_o         (cek_deger_o),
        .onbellek_gecersiz_i (onbellek_gecersiz_i),
        .bel_istek_o         (bel_istek_o),
        .bel_adres_o         (bel_adres_o),
        .bel_kabul_i         (bel_kabul_i),
        .bel_gecerli_i       (bel_gecerli_i),
        .bel_deger_i         (bel_deger_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] bellek(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            32'h0000_0100: return 32'h0000_0011;
            32'h0000_0104: return 32'h0000_0022;
            32'h0000_0108: return 32'h0000_0033;
            32'h0000_010C: return 32'h0000_0044;
            default:       return w ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Lower-memory model: accepts after kabul_gecikme cycles, streams words with gaps
    initial begin
        bel_kabul_i = 1'b0; bel_gecerli_i = 1'b0; bel_deger_i = 32'h0; onbellek_gecersiz_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bel_istek_o && !rst_i) begin
                yanit_adres = bel_adres_o;
                istek_sayisi++;
                son_istek_adres = yanit_adres;
                for (int d = 0; d < kabul_gecikme; d++) begin
                    @(negedge clk_i);
                    if (bel_istek_o !== 1'b1 || bel_adres_o !== yanit_adres) kararsiz++;
                end
                bel_kabul_i = 1'b1;
                @(negedge clk_i);
                bel_kabul_i = 1'b0;
                for (int k = 0; k < KS && !rst_i; k++) begin
                    for (int g = 0; g < bosluk; g++) @(negedge clk_i);
                    bel_gecerli_i = 1'b1;
                    bel_deger_i   = bellek(yanit_adres + 32'(4 * k));
                    if (k == gecersiz_kelime) begin
                        onbellek_gecersiz_i = 1'b1;
                        gecersiz_kelime = -1;
                    end
                    gonderilen++;
                    @(negedge clk_i);
                    bel_gecerli_i = 1'b0;
                    onbellek_gecersiz_i = 1'b0;
                end
            end
        end
    end

    // One fetch: push the expected word, stall-count until bekle drops, pop and compare
    task automatic getir(input logic [31:0] a, output int bekleme);
        logic [31:0] beklenen;
        bit tamam;
        @(negedge clk_i);
        cek_chip_select_n_i = 1'b0;
        cek_adres_i = a;
        beklenen_q.push_back(bellek(a));
        bekleme = 0;
        tamam = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!cek_bekle_o) begin
                tamam = 1'b1;
                break;
            end
            if (c == 0) begin
                toplam++;
                if (cek_deger_o !== 32'h0) $display("FAIL stall_deger adres=%h got=%h exp=00000000", a, cek_deger_o);
                else gecen++;
            end
            bekleme++;
            @(negedge clk_i);
        end
        beklenen = beklenen_q.pop_front();
        toplam++;
        if (!tamam) $display("FAIL getir_timeout adres=%h bekle still high after %0d cycles", a, bekleme);
        else if (cek_deger_o !== beklenen) $display("FAIL getir_deger adres=%h got=%h exp=%h", a, cek_deger_o, beklenen);
        else gecen++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cek_chip_select_n_i = 1'b1; cek_adres_i = 32'h0;
        repeat (3) @(negedge clk_i);
        #1;
        toplam++; if (bel_istek_o !== 1'b0) $display("FAIL reset_istek got=%b exp=0", bel_istek_o); else gecen++;
        toplam++; if (bel_adres_o !== 32'h0) $display("FAIL reset_adres got=%h exp=00000000", bel_adres_o); else gecen++;
        toplam++; if (cek_bekle_o !== 1'b0) $display("FAIL reset_bekle_idle got=%b exp=0", cek_bekle_o); else gecen++;
        cek_chip_select_n_i = 1'b0; cek_adres_i = 32'h0000_0104;
        #1;
        toplam++; if (cek_bekle_o !== 1'b1) $display("FAIL reset_first_access_miss got=%b exp=1", cek_bekle_o); else gecen++;
        toplam++; if (cek_deger_o !== 32'h0) $display("FAIL reset_deger got=%h exp=00000000", cek_deger_o); else gecen++;
        cek_chip_select_n_i = 1'b1;
        @(posedge clk_i);
        #2 rst_i = 1'b0;
    endtask

    task automatic test_cold_miss();
        int b, n0;
        n0 = istek_sayisi;
        getir(32'h0000_0104, b);
        toplam++; if (b != 6) $display("FAIL cold_stall_cycles got=%0d exp=6", b); else gecen++;
        toplam++; if (istek_sayisi - n0 != 1) $display("FAIL cold_istek_count got=%0d exp=1", istek_sayisi - n0); else gecen++;
        toplam++; if (son_istek_adres !== 32'h0000_0100) $display("FAIL cold_istek_adres got=%h exp=00000100", son_istek_adres); else gecen++;
    endtask

    task automatic test_hit();
        int b, n0;
        n0 = istek_sayisi;
        getir(32'h0000_010C, b);
        toplam++; if (b != 0) $display("FAIL hit_stall_cycles got=%0d exp=0", b); else gecen++;
        toplam++; if (istek_sayisi != n0) $display("FAIL hit_no_istek got=%0d exp=%0d", istek_sayisi, n0); else gecen++;
    endtask

    task automatic test_conflict();
        int b;
        getir(32'h0000_0200, b);
        toplam++; if (b != 6) $display("FAIL conflict_refill got=%0d exp=6", b); else gecen++;
        toplam++; if (son_istek_adres !== 32'h0000_0200) $display("FAIL conflict_adres got=%h exp=00000200", son_istek_adres); else gecen++;
        getir(32'h0000_0104, b);
        toplam++; if (b != 6) $display("FAIL conflict_remiss got=%0d exp=6", b); else gecen++;
    endtask

    task automatic test_invalidate_during_fill();
        int b, n0;
        getir(32'h0000_1010, b);
        toplam++; if (b != 6) $display("FAIL inv_prefill got=%0d exp=6", b); else gecen++;
        gecersiz_kelime = 2;
        n0 = istek_sayisi;
        getir(32'h0000_0408, b);
        toplam++; if (b != 12) $display("FAIL inv_double_fill_cycles got=%0d exp=12", b); else gecen++;
        toplam++; if (istek_sayisi - n0 != 2) $display("FAIL inv_istek_count got=%0d exp=2", istek_sayisi - n0); else gecen++;
        getir(32'h0000_1014, b);
        toplam++; if (b != 6) $display("FAIL inv_other_line_cleared got=%0d exp=6", b); else gecen++;
    endtask

    task automatic test_slow_handshake();
        int b;
        kabul_gecikme = 5; bosluk = 2; kararsiz = 0;
        getir(32'h0000_1230, b);
        kabul_gecikme = 0; bosluk = 0;
        toplam++; if (b != 2 + 5 + KS * 3) $display("FAIL slow_stall_cycles got=%0d exp=%0d", b, 2 + 5 + KS * 3); else gecen++;
        toplam++; if (kararsiz != 0) $display("FAIL slow_istek_stable got=%0d unstable cycles exp=0", kararsiz); else gecen++;
        getir(32'h0000_1238, b);
        toplam++; if (b != 0) $display("FAIL slow_word2_hit got=%0d exp=0", b); else gecen++;
        getir(32'h0000_1234, b);
        toplam++; if (b != 0) $display("FAIL slow_word1_hit got=%0d exp=0", b); else gecen++;
    endtask

    task automatic test_reset_mid_fill();
        int b, g0;
        bit goruldu;
        g0 = gonderilen;
        goruldu = 1'b0;
        @(negedge clk_i);
        cek_chip_select_n_i = 1'b0; cek_adres_i = 32'h0000_0300;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk_i);
            if (gonderilen - g0 >= 2) begin
                goruldu = 1'b1;
                break;
            end
        end
        toplam++; if (!goruldu) $display("FAIL rmf_timeout words seen=%0d exp=2", gonderilen - g0); else gecen++;
        #1 rst_i = 1'b1; cek_chip_select_n_i = 1'b1;
        #1;
        toplam++; if (bel_istek_o !== 1'b0) $display("FAIL rmf_istek got=%b exp=0", bel_istek_o); else gecen++;
        toplam++; if (dut.durum_r !== BOSTA) $display("FAIL rmf_state got=%0d exp=%0d", dut.durum_r, BOSTA); else gecen++;
        toplam++; if (dut.sayac_r !== 2'd0) $display("FAIL rmf_counter got=%0d exp=0", dut.sayac_r); else gecen++;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        getir(32'h0000_0304, b);
        toplam++; if (b != 6) $display("FAIL rmf_remiss got=%0d exp=6", b); else gecen++;
    endtask

    task automatic test_back_to_back();
        int b;
        for (int k = 0; k < KS; k++) begin
            getir(32'h0000_0300 + 32'(4 * k), b);
            toplam++; if (b != 0) $display("FAIL b2b_hit word=%0d got=%0d exp=0", k, b); else gecen++;
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_invalidate_during_fill();
        test_slow_handshake();
        test_reset_mid_fill();
        test_back_to_back();
        @(negedge clk_i);
        cek_chip_select_n_i = 1'b1;
        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule
